// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : PIDs, engine states and default limits shared by the host
//                USB transaction engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TOKEN     = 3'd1,
        ST_DATA      = 3'd2,
        ST_WAIT_HS   = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_SEND_ACK  = 3'd5,
        ST_SEND_NAK  = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    localparam int c_def_timeout   = 255;
    localparam int c_def_max_retry = 8;

    function automatic logic is_send_state(input state_t s);
        return (s == ST_TOKEN) || (s == ST_DATA) ||
               (s == ST_SEND_ACK) || (s == ST_SEND_NAK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_protocol_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_protocol_fsm_if
//  Description : Request/response bus to the R/W FSM plus the packet-layer
//                bus, seen from the transaction engine (master) and its
//                environment (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_protocol_fsm_if;

    // upstream request / response
    logic        input_ready;
    logic        send_in;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data_down;
    logic        free;
    logic        bad;
    logic        recv_ready;
    logic [63:0] data_up;

    // downstream packet layer
    logic        pkt_send;
    logic [3:0]  pkt_pid;
    logic [6:0]  pkt_addr;
    logic [3:0]  pkt_endp;
    logic [63:0] pkt_data;
    logic        pkt_sent;
    logic        pkt_rcvd;
    logic [3:0]  rx_pid;
    logic [63:0] rx_data;
    logic        rx_crc_ok;

    modport master (
        input  input_ready, send_in, addr, endp, data_down,
        input  pkt_sent, pkt_rcvd, rx_pid, rx_data, rx_crc_ok,
        output free, bad, recv_ready, data_up,
        output pkt_send, pkt_pid, pkt_addr, pkt_endp, pkt_data
    );

    modport slave (
        output input_ready, send_in, addr, endp, data_down,
        output pkt_sent, pkt_rcvd, rx_pid, rx_data, rx_crc_ok,
        input  free, bad, recv_ready, data_up,
        input  pkt_send, pkt_pid, pkt_addr, pkt_endp, pkt_data
    );

endinterface
`default_nettype wire

// File: rtl/usb_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_timeout_timer
//  Description : Device-response timer; expired flags the TIMEOUT-th cycle
//                of waiting since the last clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_timeout_timer #(
    parameter int TIMEOUT = usb_pkg::c_def_timeout
) (
    input  wire logic clk,
    input  wire logic rst_L,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int             c_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT - 1);

    logic [c_w-1:0] r_count;

    // saturates at the terminal value so a stalled enable cannot wrap
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_last)) begin
            r_count <= r_count + c_w'(1);
        end
    end

    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/usb_protocol_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : usb_protocol_fsm
//  Description : Host-side USB transaction engine: sequences token, data and
//                handshake packets with timeout, NAK and retry handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_protocol_fsm
    import usb_pkg::*;
#(
    parameter int TIMEOUT   = c_def_timeout,
    parameter int MAX_RETRY = c_def_max_retry
) (
    input  wire logic          clk,
    input  wire logic          rst_L,
    usb_protocol_fsm_if.master bus
);

    localparam int              c_aw        = $clog2(MAX_RETRY + 1);
    localparam logic [c_aw-1:0] c_max_retry = c_aw'(MAX_RETRY);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_attempt_fail;
    logic            w_rx_good;
    logic            w_send_entry;
    logic            w_is_in;
    logic [3:0]      w_pid_nxt;
    logic            w_waiting;
    logic            w_timer_clear;
    logic            w_expired;

    logic [c_aw-1:0] r_attempt;
    logic            r_send_in;
    logic [6:0]      r_addr;
    logic [3:0]      r_endp;
    logic [63:0]     r_data;
    logic [63:0]     r_data_up;
    logic            r_recv_ready;
    logic            r_pkt_send;
    logic [3:0]      r_pkt_pid;

    assign w_waiting     = (r_state == ST_WAIT_HS) || (r_state == ST_WAIT_DATA);
    assign w_timer_clear = !w_waiting &&
                           ((w_state_nxt == ST_WAIT_HS) || (w_state_nxt == ST_WAIT_DATA));

    usb_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_L   (rst_L),
        .clear   (w_timer_clear),
        .enable  (w_waiting),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_attempt_fail = 1'b0;
        w_rx_good      = 1'b0;
        w_send_entry   = 1'b0;
        w_pid_nxt      = r_pkt_pid;
        w_is_in        = (r_state == ST_IDLE) ? bus.send_in : r_send_in;

        case (r_state)
            ST_IDLE: begin
                if (bus.input_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_TOKEN;
                end
            end
            ST_TOKEN: begin
                if (bus.pkt_sent) begin
                    w_state_nxt = r_send_in ? ST_WAIT_DATA : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.pkt_sent) begin
                    w_state_nxt = ST_WAIT_HS;
                end
            end
            ST_WAIT_HS: begin
                // a reception in the expiry cycle takes priority over the timeout
                if (bus.pkt_rcvd) begin
                    if ((bus.rx_pid == PID_ACK) && bus.rx_crc_ok) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_attempt_fail = 1'b1;
                    end
                end else if (w_expired) begin
                    w_attempt_fail = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (bus.pkt_rcvd) begin
                    if (bus.rx_pid == PID_DATA0) begin
                        if (bus.rx_crc_ok) begin
                            w_rx_good   = 1'b1;
                            w_state_nxt = ST_SEND_ACK;
                        end else begin
                            w_state_nxt = ST_SEND_NAK;
                        end
                    end else begin
                        w_attempt_fail = 1'b1;
                    end
                end else if (w_expired) begin
                    w_attempt_fail = 1'b1;
                end
            end
            ST_SEND_ACK: begin
                if (bus.pkt_sent) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND_NAK: begin
                if (bus.pkt_sent) begin
                    w_attempt_fail = 1'b1;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_attempt_fail) begin
            w_state_nxt = (r_attempt < c_max_retry) ? ST_TOKEN : ST_FAIL;
        end

        w_send_entry = (w_state_nxt != r_state) && is_send_state(w_state_nxt);

        if (w_send_entry) begin
            case (w_state_nxt)
                ST_TOKEN:    w_pid_nxt = w_is_in ? PID_IN : PID_OUT;
                ST_DATA:     w_pid_nxt = PID_DATA0;
                ST_SEND_ACK: w_pid_nxt = PID_ACK;
                ST_SEND_NAK: w_pid_nxt = PID_NAK;
                default:     w_pid_nxt = r_pkt_pid;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_attempt    <= '0;
            r_send_in    <= 1'b0;
            r_addr       <= '0;
            r_endp       <= '0;
            r_data       <= '0;
            r_data_up    <= '0;
            r_recv_ready <= 1'b0;
            r_pkt_send   <= 1'b0;
            r_pkt_pid    <= '0;
        end else begin
            if (w_accept) begin
                r_attempt <= c_aw'(1);
                r_send_in <= bus.send_in;
                r_addr    <= bus.addr;
                r_endp    <= bus.endp;
                r_data    <= bus.data_down;
            end else if (w_attempt_fail && (r_attempt < c_max_retry)) begin
                r_attempt <= r_attempt + c_aw'(1);
            end

            if (w_rx_good) begin
                r_data_up <= bus.rx_data;
            end

            r_recv_ready <= (r_state == ST_SEND_ACK) && bus.pkt_sent;
            r_pkt_send   <= w_send_entry;
            r_pkt_pid    <= w_pid_nxt;
        end
    end

    // request fields are held for the whole transaction, so they feed the packet layer directly
    assign bus.free       = (r_state == ST_IDLE);
    assign bus.bad        = (r_state == ST_FAIL);
    assign bus.recv_ready = r_recv_ready;
    assign bus.data_up    = r_data_up;
    assign bus.pkt_send   = r_pkt_send;
    assign bus.pkt_pid    = r_pkt_pid;
    assign bus.pkt_addr   = r_addr;
    assign bus.pkt_endp   = r_endp;
    assign bus.pkt_data   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_usb_protocol_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_protocol_fsm
//  Description : Directed scoreboard bench for the USB transaction engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_protocol_fsm;
    import usb_pkg::*;

    localparam int TO = 255;
    localparam int MR = 8;

    typedef struct {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
        bit          is_tok;
        bit          is_data;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_L;
    always #5 clk = ~clk;

    usb_protocol_fsm_if bus();

    usb_protocol_fsm #(
        .TIMEOUT   (TO),
        .MAX_RETRY (MR)
    ) dut (
        .clk   (clk),
        .rst_L (rst_L),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    pkt_t        exp_q[$];
    logic [63:0] recv_q[$];
    logic [6:0]  cur_addr;
    logic [3:0]  cur_endp;
    logic [63:0] cur_data;
    int          tok_cnt;
    int          n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] pid);
        pkt_t p;
        p.pid     = pid;
        p.addr    = cur_addr;
        p.endp    = cur_endp;
        p.data    = cur_data;
        p.is_tok  = (pid == PID_OUT) || (pid == PID_IN);
        p.is_data = (pid == PID_DATA0);
        exp_q.push_back(p);
    endtask

    task automatic request(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d);
        cur_addr = a;
        cur_endp = e;
        cur_data = d;
        bus.input_ready = 1'b1;
        bus.send_in     = is_in;
        bus.addr        = a;
        bus.endp        = e;
        bus.data_down   = d;
        tick();
        // scramble so any late sampling of the request fields shows up
        bus.input_ready = 1'b0;
        bus.send_in     = ~is_in;
        bus.addr        = ~a;
        bus.endp        = ~e;
        bus.data_down   = ~d;
    endtask

    task automatic wait_pkt(input string tag);
        pkt_t e;
        int   k = 0;
        while (!bus.pkt_send && k < 600) begin
            tick();
            k++;
        end
        chk({tag, "_send_seen"}, 64'(bus.pkt_send), 64'(1));
        chk({tag, "_qsize"}, 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_pid"}, 64'(bus.pkt_pid), 64'(e.pid));
            if (e.is_tok) begin
                chk({tag, "_addr"}, 64'(bus.pkt_addr), 64'(e.addr));
                chk({tag, "_endp"}, 64'(bus.pkt_endp), 64'(e.endp));
            end
            if (e.is_data) begin
                chk({tag, "_data"}, bus.pkt_data, e.data);
            end
        end
    endtask

    task automatic sent();
        bus.pkt_sent = 1'b1;
        tick();
        bus.pkt_sent = 1'b0;
    endtask

    task automatic rcv(input logic [3:0] pid, input logic [63:0] d, input logic crc);
        bus.pkt_rcvd  = 1'b1;
        bus.rx_pid    = pid;
        bus.rx_data   = d;
        bus.rx_crc_ok = crc;
        tick();
        bus.pkt_rcvd  = 1'b0;
        bus.rx_data   = {$urandom, $urandom};
        bus.rx_crc_ok = 1'b0;
    endtask

    task automatic check_recv(input string tag);
        logic [63:0] d;
        chk({tag, "_recv_ready"}, 64'(bus.recv_ready), 64'(1));
        chk({tag, "_free"}, 64'(bus.free), 64'(1));
        chk({tag, "_rqsize"}, 64'(recv_q.size()), 64'(1));
        if (recv_q.size() > 0) begin
            d = recv_q.pop_front();
            chk({tag, "_data_up"}, bus.data_up, d);
        end
        tick();
        chk({tag, "_recv_once"}, 64'(bus.recv_ready), 64'(0));
    endtask

    task automatic out_flow(input string tag, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d);
        request(1'b0, a, e, d);
        push(PID_OUT);
        push(PID_DATA0);
        wait_pkt({tag, "_tok"});
        sent();
        wait_pkt({tag, "_data"});
        sent();
        repeat (3) tick();
        rcv(PID_ACK, 64'h0, 1'b1);
        chk({tag, "_free"}, 64'(bus.free), 64'(1));
        chk({tag, "_no_bad"}, 64'(bus.bad), 64'(0));
        chk({tag, "_no_recv"}, 64'(bus.recv_ready), 64'(0));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_L           = 1'b0;
        bus.input_ready = 1'b0;
        bus.send_in     = 1'b0;
        bus.addr        = '0;
        bus.endp        = '0;
        bus.data_down   = '0;
        bus.pkt_sent    = 1'b0;
        bus.pkt_rcvd    = 1'b0;
        bus.rx_pid      = '0;
        bus.rx_data     = '0;
        bus.rx_crc_ok   = 1'b0;
        repeat (3) tick();

        chk("rst_free", 64'(bus.free), 64'(1));
        chk("rst_bad", 64'(bus.bad), 64'(0));
        chk("rst_recv_ready", 64'(bus.recv_ready), 64'(0));
        chk("rst_pkt_send", 64'(bus.pkt_send), 64'(0));
        chk("rst_data_up", bus.data_up, 64'h0);
        chk("rst_pkt_pid", 64'(bus.pkt_pid), 64'(0));
        chk("rst_pkt_addr", 64'(bus.pkt_addr), 64'(0));
        chk("rst_pkt_data", bus.pkt_data, 64'h0);
        rst_L = 1'b1;
        tick();

        // OUT with a stray input_ready while busy
        request(1'b0, 7'd5, 4'd4, 64'h1234);
        push(PID_OUT);
        push(PID_DATA0);
        wait_pkt("t1_tok");
        sent();
        wait_pkt("t1_data");
        sent();
        bus.input_ready = 1'b1;
        tick();
        bus.input_ready = 1'b0;
        chk("t1_busy_free", 64'(bus.free), 64'(0));
        rcv(PID_ACK, 64'h0, 1'b1);
        chk("t1_free", 64'(bus.free), 64'(1));
        chk("t1_no_bad", 64'(bus.bad), 64'(0));
        chk("t1_no_recv", 64'(bus.recv_ready), 64'(0));
        tick();
        chk("t1_no_extra_send", 64'(bus.pkt_send), 64'(0));

        // IN with good data, then data_up held through an OUT
        request(1'b1, 7'd5, 4'd8, 64'h0);
        push(PID_IN);
        wait_pkt("t2_tok");
        sent();
        repeat (3) tick();
        push(PID_ACK);
        recv_q.push_back(64'hDEADBEEF_CAFEF00D);
        rcv(PID_DATA0, 64'hDEADBEEF_CAFEF00D, 1'b1);
        wait_pkt("t2_ack");
        sent();
        check_recv("t2");
        out_flow("t2_out", 7'd3, 4'd1, 64'hAAAA_5555_0000_FFFF);
        chk("t2_data_up_held", bus.data_up, 64'hDEADBEEF_CAFEF00D);

        // IN: two NAKs, then good data
        request(1'b1, 7'd17, 4'd2, 64'h0);
        tok_cnt = 0;
        for (int a = 0; a < 3; a++) begin
            push(PID_IN);
            wait_pkt("t3_tok");
            if (bus.pkt_send && bus.pkt_pid == PID_IN) tok_cnt++;
            sent();
            tick();
            if (a < 2) begin
                rcv(PID_NAK, 64'h0, 1'b1);
            end else begin
                push(PID_ACK);
                recv_q.push_back(64'h0123_4567_89AB_CDEF);
                rcv(PID_DATA0, 64'h0123_4567_89AB_CDEF, 1'b1);
                wait_pkt("t3_ack");
                sent();
            end
        end
        chk("t3_tok_cnt", 64'(tok_cnt), 64'(3));
        chk("t3_no_bad", 64'(bus.bad), 64'(0));
        check_recv("t3");

        // OUT with a silent device: every attempt times out, then bad
        request(1'b0, 7'd9, 4'd2, 64'h55);
        tok_cnt = 0;
        for (int a = 0; a < MR; a++) begin
            push(PID_OUT);
            push(PID_DATA0);
            wait_pkt("t4_tok");
            if (bus.pkt_send && bus.pkt_pid == PID_OUT) tok_cnt++;
            sent();
            wait_pkt("t4_data");
            sent();
            n = 0;
            while (!bus.pkt_send && !bus.bad && n < 400) begin
                tick();
                n++;
            end
            chk("t4_timeout_cycles", 64'(n), 64'(TO));
            chk("t4_bad_on_last", 64'(bus.bad), 64'(a == MR - 1));
        end
        chk("t4_tok_cnt", 64'(tok_cnt), 64'(MR));
        chk("t4_bad_not_free", 64'(bus.free), 64'(0));
        tick();
        chk("t4_bad_one_cycle", 64'(bus.bad), 64'(0));
        chk("t4_free_after", 64'(bus.free), 64'(1));
        chk("t4_data_up_kept", bus.data_up, 64'h0123_4567_89AB_CDEF);

        // IN with a corrupt DATA0: NAK, retry, then good data
        request(1'b1, 7'd33, 4'd7, 64'h0);
        push(PID_IN);
        wait_pkt("t5_tok");
        sent();
        push(PID_NAK);
        rcv(PID_DATA0, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0);
        wait_pkt("t5_nak");
        chk("t5_data_up_unchanged", bus.data_up, 64'h0123_4567_89AB_CDEF);
        push(PID_IN);
        sent();
        wait_pkt("t5_retry_tok");
        sent();
        push(PID_ACK);
        recv_q.push_back(64'hFEED_FACE_1357_2468);
        rcv(PID_DATA0, 64'hFEED_FACE_1357_2468, 1'b1);
        wait_pkt("t5_ack");
        sent();
        check_recv("t5");

        // reset while waiting for IN data
        request(1'b1, 7'd44, 4'd3, 64'h0);
        push(PID_IN);
        wait_pkt("t6_tok");
        sent();
        repeat (3) tick();
        chk("t6_busy", 64'(bus.free), 64'(0));
        #2;
        rst_L = 1'b0;
        #1;
        chk("t6_async_free", 64'(bus.free), 64'(1));
        chk("t6_no_bad", 64'(bus.bad), 64'(0));
        tick();
        chk("t6_rst_data_up", bus.data_up, 64'h0);
        chk("t6_rst_bad", 64'(bus.bad), 64'(0));
        rst_L = 1'b1;
        tick();
        out_flow("t6_out", 7'd12, 4'd6, 64'h7777_8888_9999_AAAA);

        chk("end_exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_protocol_fsm.md
Name: usb_protocol_fsm

Overview:
- Host-side USB transaction engine, directly downstream of the read/write FSM.
- Takes one OUT or IN transaction request (address, endpoint, 64-bit payload) and sequences token, data and handshake packets through the packet layer below.
- Handles device timeouts, NAKs, corrupt data and retries.
- Reports completion (free), failure (bad) and received IN data (recv_ready, data_up) back up.

Parameters:
- TIMEOUT, 255: cycles to wait for a device response after our last packet finishes sending.
- MAX_RETRY, 8: total attempts per transaction before failure is declared.

Ports:
- clk  in  1  system clock
- rst_L  in  1  reset; asynchronous, active-low
- input_ready  in  1  request valid from the R/W FSM; sampled only while free=1
- send_in  in  1  1 = IN transaction, 0 = OUT transaction
- addr  in  7  device address
- endp  in  4  endpoint
- data_down  in  64  OUT payload
- free  out  1  engine idle, ready to accept a request
- bad  out  1  one-cycle pulse: transaction abandoned
- recv_ready  out  1  one-cycle pulse: data_up holds a valid IN payload
- data_up  out  64  last good IN payload
- pkt_send  out  1  one-cycle pulse: packet layer starts sending the current packet
- pkt_pid  out  4  PID to send
- pkt_addr  out  7  token address field
- pkt_endp  out  4  token endpoint field
- pkt_data  out  64  DATA0 payload
- pkt_sent  in  1  pulse: packet fully transmitted
- pkt_rcvd  in  1  pulse: packet received from the device
- rx_pid  in  4  received PID, valid with pkt_rcvd
- rx_data  in  64  received payload, valid with pkt_rcvd
- rx_crc_ok  in  1  received CRC good, valid with pkt_rcvd

Behaviour:
- Reset:
  - Outputs after reset: free=1 (IDLE); bad, recv_ready and pkt_send = 0; data_up, pkt_* fields and internal counters = 0.
  - Reset mid-transaction aborts immediately to IDLE; no bad pulse is produced.
- PIDs: OUT=0001, IN=1001, DATA0=0011, ACK=0010, NAK=1010, STALL=1110.
- free is high exactly in IDLE.
- Request acceptance:
  - A request is accepted on a clock edge where free and input_ready are both 1.
  - send_in, addr, endp and data_down are latched on acceptance; later changes to these inputs are ignored.
  - The attempt count is cleared to 1 on acceptance.
  - input_ready while free=0 is ignored.
- Each packet send:
  - pkt_send pulses one cycle on entry to a send state.
  - pkt_pid, pkt_addr, pkt_endp and pkt_data stay stable until pkt_sent.
- States:
  - IDLE: on accept, go to TOKEN.
  - TOKEN: send OUT or IN token. On pkt_sent, go to DATA (OUT) or WAIT_DATA (IN).
  - DATA: send DATA0 carrying the latched payload. On pkt_sent, go to WAIT_HS.
  - WAIT_HS:
    - Timer runs.
    - pkt_rcvd with ACK: success, go to IDLE.
    - NAK, timeout, bad CRC or any other PID: failed attempt.
  - WAIT_DATA:
    - Timer runs.
    - pkt_rcvd with DATA0 and rx_crc_ok=1: latch rx_data into the holding register, go to SEND_ACK.
    - DATA0 with bad CRC: go to SEND_NAK.
    - Device NAK, timeout or other PID: failed attempt.
  - SEND_ACK: send ACK. On pkt_sent: success; recv_ready pulses in the first IDLE cycle.
  - SEND_NAK: send NAK. On pkt_sent: failed attempt.
  - FAIL: one cycle, bad=1, free=0; then IDLE.
- Failed attempt:
  - If attempt count < MAX_RETRY: increment it and go to TOKEN.
  - Otherwise go to FAIL.
- Timer:
  - Cleared on entry to WAIT_HS and WAIT_DATA.
  - Counts every cycle in those states.
  - Expiry is count == TIMEOUT-1.
  - If pkt_rcvd and expiry occur in the same cycle, pkt_rcvd wins.
- data_up:
  - Changes only on a good DATA0 reception.
  - Holds its value through IDLE and later OUT transactions, so the R/W FSM may sample it any cycle after free rises.
- bad and free are never high in the same cycle.
- An OUT success produces no recv_ready pulse.
- pkt_rcvd outside WAIT states is ignored.

Decomposition:
- Package usb_pkg:
  - pid_t enum holding the six PIDs.
  - Engine state enum.
  - TIMEOUT and MAX_RETRY defaults.
- Sub-module usb_timeout_timer:
  - Inputs: clear, enable.
  - Output: expired.
  - Counter width $clog2(TIMEOUT).

Test Plan:
- OUT addr=5 endp=4 data=0x1234; sequence pkt_sent, pkt_sent, then ACK -> pkt_pid sequence OUT, DATA0 with pkt_data=0x1234; free returns 1; no bad, no recv_ready.
- IN addr=5 endp=8; device DATA0 0xDEADBEEF_CAFEF00D with CRC ok -> host sends ACK; recv_ready pulses once; data_up=0xDEADBEEFCAFEF00D, held through a following OUT transaction.
- IN; device NAK twice then good DATA0 -> three IN tokens observed; success; no bad.
- OUT; device silent -> 8 attempts, each timing out at TIMEOUT cycles; bad pulses exactly one cycle with free=0; then free=1.
- IN; DATA0 with rx_crc_ok=0 -> host sends NAK then retries with an IN token; data_up unchanged.
- rst_L low during WAIT_DATA -> free=1 asynchronously, no bad pulse; a new request issued afterwards is accepted normally.
